pipe_skid: RTL

PIPE_SKID -- requirements
Module: pipe_skid

---
 rtl/pipe_skid_pkg.sv | 26 ++
 rtl/pipe_ctrl_defs.sv | 9 +
 rtl/pipe_skid_dff.sv | 21 ++
 rtl/pipe_skid.sv | 110 +++++++++++
 4 files changed

// File: rtl/pipe_skid_pkg.sv
// Constants and helpers for the two-entry skid buffer.
`ifndef PIPE_CTRL_DEFS_SV
`include "pipe_ctrl_defs.sv"
`endif

package pipe_skid_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_EMPTY = `PIPE_ST_EMPTY;
    localparam logic [STATE_W-1:0] ST_ONE   = `PIPE_ST_ONE;
    localparam logic [STATE_W-1:0] ST_TWO   = `PIPE_ST_TWO;

    // Number of held entries implied by a state encoding; the unused code reads as empty.
    function automatic logic [1:0] state_count(input logic [STATE_W-1:0] s);
        logic [1:0] c;
        c = 2'd0;
        case (s)
            ST_ONE:  c = 2'd1;
            ST_TWO:  c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_defs.sv
// Shared pipeline-control state encodings; macro-only so it is safe to include or compile standalone.
`ifndef PIPE_CTRL_DEFS_SV
`define PIPE_CTRL_DEFS_SV

`define PIPE_ST_EMPTY 2'd0
`define PIPE_ST_ONE   2'd1
`define PIPE_ST_TWO   2'd2

`endif

// File: rtl/pipe_skid_dff.sv
// N-bit write-enabled flipflop with synchronous active-high clear.
module pipe_skid_dff #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Load on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry elastic buffer (main + skid) giving registered ready and full throughput.
module pipe_skid
    import pipe_skid_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               in_xfer;
    logic               out_xfer;
    logic               main_en;
    logic               skid_en;
    logic [N-1:0]       main_d;
    logic [N-1:0]       main_q;
    logic [N-1:0]       skid_q;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // State register plus handshake flags precomputed from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != ST_TWO);
            out_valid_q <= (next_state == ST_ONE) || (next_state == ST_TWO);
        end
    end

    // Next-state and data-register load decisions.
    always_comb begin
        next_state = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = in_data;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_en    = 1'b1;
                    next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en    = 1'b1;
                    next_state = ST_TWO;
                end else if (out_xfer) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                main_d = skid_q;
                if (out_xfer) begin
                    main_en    = 1'b1;
                    next_state = ST_ONE;
                end
            end
            default: begin
                next_state = ST_EMPTY;
            end
        endcase
        // Flush drops everything held and anything offered this cycle.
        if (flush) begin
            next_state = ST_EMPTY;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
    end

    pipe_skid_dff #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_skid_dff #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_count(state);

endmodule
